// File: rtl/dif_radix2_64p_bf.sv
// -----------------------------------------------------------------------------
// dif_radix2_64p_bf
//
// Radix-2 decimation-in-frequency butterfly stage with single-delay feedback
// (SDF), for the 64-point pipeline. It feeds dif_radix2_64p_tm directly.
//
// For each frame, the stage accepts DELAY samples and parks them in the delay
// line (fill phase). For the next DELAY samples it forms a + b and a - b, where
// a is the parked sample and b is the new one (butterfly phase). The sum goes to
// dout right away. The difference goes back into the delay line and drains to
// dout during the next fill phase. The stage therefore produces one output per
// accepted input: DELAY sums, then DELAY differences.
//
// tm64_ctrl is the twiddle index for the sample that is currently on dout:
// {bit-reversed ocnt[2:0], ocnt[5:3]}. Output index 0 is the first sum of a
// frame.
//
// Configuration macro:
//   DIF_BF_SCALE_EN  defined   -> every value placed on dout is (v + 1) >>> 1
//                                 (round half up). The delay line keeps the
//                                 unscaled differences.
//                    undefined -> dout carries v unscaled.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   halt_ctrl   in   1 = accept din and step the stage, 0 = freeze all state
//   din_real    in   [DATA_WIDTH_IN-1:0]  signed input, real part
//   din_imag    in   [DATA_WIDTH_IN-1:0]  signed input, imaginary part
//   dout_real   out  [DATA_WIDTH_OUT-1:0] signed registered output, real part
//   dout_imag   out  [DATA_WIDTH_OUT-1:0] signed registered output, imaginary part
//   dout_valid  out  sticky flag, set by the first butterfly-phase accept
//   tm64_ctrl   out  [5:0] twiddle select, aligned with dout
// -----------------------------------------------------------------------------
module dif_radix2_64p_bf #(
  parameter int DATA_WIDTH_IN  = 10,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
  parameter int DELAY          = 32   // power of 2, 1..32 (64 >> stage)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      halt_ctrl,
  input  logic [DATA_WIDTH_IN-1:0]  din_real,
  input  logic [DATA_WIDTH_IN-1:0]  din_imag,
  output logic [DATA_WIDTH_OUT-1:0] dout_real,
  output logic [DATA_WIDTH_OUT-1:0] dout_imag,
  output logic                      dout_valid,
  output logic [5:0]                tm64_ctrl
);

  // Bit of the input counter that selects fill (0) or butterfly (1).
  localparam int PHASE_BIT = $clog2(DELAY);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [5:0]                       icnt_q, icnt_d;
  logic [5:0]                       ocnt_q, ocnt_d;
  logic signed [DATA_WIDTH_OUT-1:0] dout_real_q, dout_real_d;
  logic signed [DATA_WIDTH_OUT-1:0] dout_imag_q, dout_imag_d;
  logic                             dout_valid_q, dout_valid_d;
  logic [5:0]                       tm64_ctrl_q, tm64_ctrl_d;

  // Delay line as a shift register. Entry 0 is written on each accept, and
  // entry DELAY-1 is the head: the value written DELAY accepts earlier.
  logic signed [DATA_WIDTH_OUT-1:0] line_re_q [DELAY];
  logic signed [DATA_WIDTH_OUT-1:0] line_im_q [DELAY];
  logic signed [DATA_WIDTH_OUT-1:0] line_re_d [DELAY];
  logic signed [DATA_WIDTH_OUT-1:0] line_im_d [DELAY];

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic                             phase;
  logic signed [DATA_WIDTH_OUT-1:0] a_re, a_im;       // delay-line head
  logic signed [DATA_WIDTH_OUT-1:0] b_re, b_im;       // sign-extended input
  logic signed [DATA_WIDTH_OUT-1:0] sum_re, sum_im;
  logic signed [DATA_WIDTH_OUT-1:0] dif_re, dif_im;
  logic signed [DATA_WIDTH_OUT-1:0] out_re, out_im;   // value bound for dout

  assign phase  = icnt_q[PHASE_BIT];
  assign a_re   = line_re_q[DELAY-1];
  assign a_im   = line_im_q[DELAY-1];
  assign b_re   = DATA_WIDTH_OUT'($signed(din_real));
  assign b_im   = DATA_WIDTH_OUT'($signed(din_imag));
  // Inputs are sign-extended by one bit, so sums and differences cannot wrap.
  assign sum_re = a_re + b_re;
  assign sum_im = a_im + b_im;
  assign dif_re = a_re - b_re;
  assign dif_im = a_im - b_im;
  assign out_re = phase ? sum_re : a_re;
  assign out_im = phase ? sum_im : a_im;

  // Optional output scaling. One extra bit keeps v + 1 from overflowing when
  // v is the largest positive value.
  function automatic logic signed [DATA_WIDTH_OUT-1:0] scale_out(
    input logic signed [DATA_WIDTH_OUT-1:0] v
  );
`ifdef DIF_BF_SCALE_EN
    logic signed [DATA_WIDTH_OUT:0] t;
    t = {v[DATA_WIDTH_OUT-1], v} + (DATA_WIDTH_OUT+1)'(1);
    return t[DATA_WIDTH_OUT:1];
`else
    return v;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default before any branch. Without
    // it, a path that skips an assignment would infer a latch.
    icnt_d       = icnt_q;
    ocnt_d       = ocnt_q;
    dout_real_d  = dout_real_q;
    dout_imag_d  = dout_imag_q;
    dout_valid_d = dout_valid_q;
    tm64_ctrl_d  = tm64_ctrl_q;
    line_re_d    = line_re_q;
    line_im_d    = line_im_q;

    if (halt_ctrl) begin
      icnt_d = icnt_q + 6'd1;

      for (int i = DELAY - 1; i > 0; i--) begin
        line_re_d[i] = line_re_q[i-1];
        line_im_d[i] = line_im_q[i-1];
      end
      // Fill parks the raw input. Butterfly parks the difference, which is
      // drained to dout during the next fill phase.
      line_re_d[0] = phase ? dif_re : b_re;
      line_im_d[0] = phase ? dif_im : b_im;

      dout_real_d = scale_out(out_re);
      dout_imag_d = scale_out(out_im);

      if (phase) begin
        dout_valid_d = 1'b1;
      end

      // ocnt_q is the index of the sample being placed on dout now.
      if (dout_valid_q || phase) begin
        ocnt_d      = ocnt_q + 6'd1;
        tm64_ctrl_d = {ocnt_q[0], ocnt_q[1], ocnt_q[2], ocnt_q[5:3]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments.
  // Blocking assignments here would let one flop see another's new value in
  // the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q       <= '0;
      ocnt_q       <= '0;
      dout_real_q  <= '0;
      dout_imag_q  <= '0;
      dout_valid_q <= 1'b0;
      tm64_ctrl_q  <= '0;
    end else begin
      icnt_q       <= icnt_d;
      ocnt_q       <= ocnt_d;
      dout_real_q  <= dout_real_d;
      dout_imag_q  <= dout_imag_d;
      dout_valid_q <= dout_valid_d;
      tm64_ctrl_q  <= tm64_ctrl_d;
    end
  end

  // NOTE: the delay line has no reset. After reset it is always written by a
  // full fill phase before it is read as butterfly data, and the garbage it
  // shows before then is masked by dout_valid. Leaving it unreset lets it map
  // to plain storage.
  always_ff @(posedge clk) begin
    line_re_q <= line_re_d;
    line_im_q <= line_im_d;
  end

  assign dout_real  = dout_real_q;
  assign dout_imag  = dout_imag_q;
  assign dout_valid = dout_valid_q;
  assign tm64_ctrl  = tm64_ctrl_q;

endmodule

// File: tb/tb_dif_radix2_64p_bf.sv
// -----------------------------------------------------------------------------
// tb_dif_radix2_64p_bf
//
// Testbench for the 64-point radix-2 DIF butterfly stage with DELAY = 32.
//
// The reference model works one frame at a time. For input samples x[0..63]
// it expects:
//   - outputs 0..31:  x[k] + x[k+32], each sum appearing on the accept of x[k+32];
//   - outputs 32..63: x[k] - x[k+32], appearing on the accept of sample k of
//     the next frame.
// The expected twiddle index for output n is {rev3(n[2:0]), n[5:3]}.
//
// Expected values are queued as each sample is issued. A separate monitor
// process pops and compares one entry after each accepted edge on which the
// DUT shows dout_valid.
// -----------------------------------------------------------------------------
module tb_dif_radix2_64p_bf;

  localparam int DW_IN  = 10;
  localparam int DW_OUT = 11;

  logic              clk;
  logic              rst_n;
  logic              halt_ctrl;
  logic [DW_IN-1:0]  din_real;
  logic [DW_IN-1:0]  din_imag;
  logic [DW_OUT-1:0] dout_real;
  logic [DW_OUT-1:0] dout_imag;
  logic              dout_valid;
  logic [5:0]        tm64_ctrl;

  dif_radix2_64p_bf #(
    .DATA_WIDTH_IN  (DW_IN),
    .DATA_WIDTH_OUT (DW_OUT),
    .DELAY          (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt_ctrl  (halt_ctrl),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .dout_valid (dout_valid),
    .tm64_ctrl  (tm64_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int re;
    int im;
    int tm;
    int idx;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int  x_re [64];
  int  x_im [64];
  int  d_re [32];
  int  d_im [32];
  int  m_icnt  = 0;
  bit  m_valid = 1'b0;

  function automatic int scl(input int v);
`ifdef DIF_BF_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic int tm_of(input int n);
    int b0, b1, b2;
    b0 = n % 2;
    b1 = (n / 2) % 2;
    b2 = (n / 4) % 2;
    return b0 * 32 + b1 * 16 + b2 * 8 + n / 8;
  endfunction

  function automatic void push_exp(input int idx, input int re, input int im);
    exp_t e;
    e.idx = idx;
    e.re  = scl(re);
    e.im  = scl(im);
    e.tm  = tm_of(idx);
    sb.push_back(e);
    last_exp = e;
  endfunction

  function automatic void model_accept(input int re, input int im);
    int n;
    n = m_icnt;
    if (n >= 32) begin
      push_exp(n - 32, x_re[n-32] + re, x_im[n-32] + im);
      d_re[n-32] = x_re[n-32] - re;
      d_im[n-32] = x_im[n-32] - im;
      m_valid = 1'b1;
    end else begin
      x_re[n] = re;
      x_im[n] = im;
      if (m_valid) push_exp(n + 32, d_re[n], d_im[n]);
    end
    m_icnt = (n + 1) % 64;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers: drive 2 time units after the rising edge
  // ---------------------------------------------------------------------------
  task automatic send(input int re, input int im);
    din_real  = DW_IN'(re);
    din_imag  = DW_IN'(im);
    halt_ctrl = 1'b1;
    model_accept(re, im);
    @(posedge clk);
    #2;
    halt_ctrl = 1'b0;
  endtask

  task automatic idle(input int n);
    halt_ctrl = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int rnd_s10();
    return int'($urandom_range(1023)) - 512;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compare one queued expectation per accepted, valid output
  // ---------------------------------------------------------------------------
  initial begin
    bit   acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = halt_ctrl && rst_n;
      @(negedge clk);
      if (acc && dout_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got re=%0d tm=%0d, expected no output",
                   $signed(dout_real), tm64_ctrl);
        end else begin
          e = sb.pop_front();
          check($sformatf("dout_real[%0d]", e.idx), int'($signed(dout_real)), e.re);
          check($sformatf("dout_imag[%0d]", e.idx), int'($signed(dout_imag)), e.im);
          check($sformatf("tm64_ctrl[%0d]", e.idx), int'(tm64_ctrl), e.tm);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    halt_ctrl = 1'b0;
    din_real  = '0;
    din_imag  = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dout_real",  int'(dout_real),  0);
    check("reset_dout_imag",  int'(dout_imag),  0);
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_tm64_ctrl",  int'(tm64_ctrl),  0);
    rst_n = 1'b1;
    idle(2);

    // DC frame: 32 sums of 2, then 32 differences of 0 (drained below).
    for (int i = 0; i < 64; i++) send(1, 0);
    // Impulse frame: its fill phase drains the DC differences.
    for (int i = 0; i < 64; i++) send((i == 0) ? 100 : 0, 0);
    // Extremes frame.
    for (int i = 0; i < 64; i++) send(-512, 511);
    // DC again, with a 5-cycle halt at icnt=40 and a reset at icnt=45.
    for (int i = 0; i < 40; i++) send(1, 0);
    halt_ctrl = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      check("halt_dout_real",  int'($signed(dout_real)), last_exp.re);
      check("halt_dout_imag",  int'($signed(dout_imag)), last_exp.im);
      check("halt_tm64_ctrl",  int'(tm64_ctrl),          last_exp.tm);
      check("halt_dout_valid", int'(dout_valid),         1);
    end
    for (int i = 40; i < 45; i++) send(1, 0);

    // Assert reset between edges, after the monitor has consumed the last output.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_dout_real",  int'(dout_real),  0);
    check("midreset_dout_imag",  int'(dout_imag),  0);
    check("midreset_dout_valid", int'(dout_valid), 0);
    check("midreset_tm64_ctrl",  int'(tm64_ctrl),  0);
    check("midreset_pending",    sb.size(),        0);
    sb.delete();
    m_icnt  = 0;
    m_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);

    // Restream: one frame with halt toggling every cycle, then a frame with
    // random gaps, then 32 more accepts to drain the differences.
    for (int i = 0; i < 64; i++) begin
      send(rnd_s10(), rnd_s10());
      idle(1);
    end
    for (int i = 0; i < 96; i++) begin
      send(rnd_s10(), rnd_s10());
      idle(int'($urandom_range(2)));
    end

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
